// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame-length helper and parameter legality.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  localparam int unsigned UART_CNT_W = 4;

  // Bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                              input int unsigned stop_bits,
                                              input int unsigned parity_en);
    return 1 + data_bits + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

  function automatic bit params_legal(input int unsigned data_bits,
                                      input int unsigned stop_bits,
                                      input int unsigned parity_en,
                                      input int unsigned parity_odd);
    return (data_bits >= 5) && (data_bits <= 9) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (parity_en <= 1) && (parity_odd <= 1);
  endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter paced by an external one-cycle bit-rate tick; frames one word
// per valid/ready handshake as start, LSB-first data, optional parity, stop bits.
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic                 TICK_IN,
  input  logic [DATA_BITS-1:0] DATA_IN,
  input  logic                 VALID_IN,
  output logic                 READY_OUT,
  output logic                 TX_OUT,
  output logic                 BUSY_OUT
);

  localparam int unsigned CNT_W = UART_CNT_W;

  if (!params_legal(DATA_BITS, STOP_BITS, PARITY_EN, PARITY_ODD)) begin : g_bad_params
    $fatal(1, "uart_tx_tick: illegal parameter combination");
  end

  uart_state_e            state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   par_q, par_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic: every transition except the accept is gated by TICK_IN.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (VALID_IN) begin
          shift_d = DATA_IN;
          par_d   = (^DATA_IN) ^ 1'(PARITY_ODD);
          busy_d  = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (TICK_IN) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (TICK_IN) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (TICK_IN) begin
          if (cnt_inc < CNT_W'(DATA_BITS)) begin
            // Bit 0 is already on the line, so the next bit sits at index 1.
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_inc;
          end else if (PARITY_EN != 0) begin
            tx_d    = par_q;
            state_d = PARITY;
          end else begin
            tx_d    = 1'b1;
            cnt_d   = '0;
            state_d = STOP;
          end
        end
      end
      PARITY: begin
        if (TICK_IN) begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (TICK_IN) begin
          if (cnt_inc < CNT_W'(STOP_BITS)) begin
            cnt_d = cnt_inc;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign READY_OUT = (state_q == IDLE);
  assign TX_OUT    = tx_q;
  assign BUSY_OUT  = busy_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Self-checking bench for uart_tx_tick: three parameterisations, directed and random
// frames checked cycle by cycle against a frame-bit list built from the word.
module tb_uart_tx_tick;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] din  [3];
  logic       vin  [3];
  logic       tx   [3];
  logic       busy [3];
  logic       rdy  [3];

  int checks   = 0;
  int failures = 0;
  int period   = 4;
  int phase    = 0;

  int pe_c [3] = '{0, 1, 1};
  int po_c [3] = '{0, 0, 1};
  int sb_c [3] = '{1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_tick u0 (
    .CLK_IN(clk), .RST_IN(rst), .TICK_IN(tick), .DATA_IN(din[0]), .VALID_IN(vin[0]),
    .READY_OUT(rdy[0]), .TX_OUT(tx[0]), .BUSY_OUT(busy[0])
  );

  uart_tx_tick #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .CLK_IN(clk), .RST_IN(rst), .TICK_IN(tick), .DATA_IN(din[1]), .VALID_IN(vin[1]),
    .READY_OUT(rdy[1]), .TX_OUT(tx[1]), .BUSY_OUT(busy[1])
  );

  uart_tx_tick #(.STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .CLK_IN(clk), .RST_IN(rst), .TICK_IN(tick), .DATA_IN(din[2]), .VALID_IN(vin[2]),
    .READY_OUT(rdy[2]), .TX_OUT(tx[2]), .BUSY_OUT(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive the tick for the coming edge, then advance to just after that edge.
  task automatic clk_step(output bit t);
    t = (phase >= period - 1);
    phase = t ? 0 : phase + 1;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  // Send one word on instance idx and check every clock of its frame.
  task automatic run_frame(input int idx, input logic [7:0] w, input bit keep,
                           input logic [7:0] nxt, input bit disturb);
    bit   q[$];
    bit   t;
    bit   p;
    bit   done;
    logic exp;
    int   n;
    int   seen;
    int   clocks;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(w[i]);
    if (pe_c[idx] != 0) begin
      p = 1'b0;
      for (int i = 0; i < 8; i++) p = p ^ w[i];
      q.push_back(p ^ (po_c[idx] != 0));
    end
    for (int i = 0; i < sb_c[idx]; i++) q.push_back(1'b1);
    n = q.size();

    chk($sformatf("u%0d ready_pre", idx), rdy[idx], 1);
    din[idx] = w;
    vin[idx] = 1'b1;
    clk_step(t);
    chk($sformatf("u%0d busy_accept", idx), busy[idx], 1);
    chk($sformatf("u%0d ready_accept", idx), rdy[idx], 0);
    chk($sformatf("u%0d tx_accept", idx), tx[idx], 1);
    vin[idx] = keep;
    din[idx] = keep ? nxt : ~w;

    seen = 0;
    clocks = 0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (disturb) begin
        vin[idx] = (seen == 3);
        din[idx] = (seen == 3) ? 8'(w + 8'd17) : ~w;
      end
      clk_step(t);
      clocks++;
      if (t) begin
        seen++;
        if (seen == 1) chk($sformatf("u%0d sync_wait_le_period", idx), clocks <= period, 1);
      end
      exp = (seen == 0 || seen > n) ? 1'b1 : q[seen-1];
      chk($sformatf("u%0d tx w=%02h tick=%0d", idx, w, seen), tx[idx], exp);
      chk($sformatf("u%0d busy tick=%0d", idx, seen), busy[idx], seen <= n);
      if (seen == n + 1) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL u%0d frame_timeout: observed ticks %0d expected %0d", idx, seen, n + 1);
    end
    vin[idx] = keep;
    chk($sformatf("u%0d ready_post", idx), rdy[idx], 1);
  endtask

  initial begin
    bit t;
    int seen;
    int idx;
    logic [7:0] w;
    tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i] = 8'h00;
      vin[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d reset tx", i), tx[i], 1);
      chk($sformatf("u%0d reset busy", i), busy[i], 0);
      chk($sformatf("u%0d reset ready", i), rdy[i], 1);
    end
    rst = 1'b0;
    clk_step(t);

    // Default framing, alternating bits, tick every 4 clocks.
    period = 4;
    run_frame(0, 8'h55, 1'b0, 8'h00, 1'b0);

    // Even and odd parity on the same word.
    run_frame(1, 8'h07, 1'b0, 8'h00, 1'b0);
    run_frame(2, 8'h07, 1'b0, 8'h00, 1'b0);

    // Two stop bits with VALID held across two words; second accepted once.
    run_frame(2, 8'hFF, 1'b1, 8'h81, 1'b0);
    run_frame(2, 8'h81, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      clk_step(t);
      chk("u2 no_reaccept busy", busy[2], 0);
      chk("u2 no_reaccept tx", tx[2], 1);
    end

    // Reset in the middle of the data bits.
    din[0] = 8'hC0;
    vin[0] = 1'b1;
    clk_step(t);
    vin[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 200 && seen < 4; c++) begin
      clk_step(t);
      if (t) seen++;
    end
    chk("u0 pre_reset busy", busy[0], 1);
    chk("u0 pre_reset tx data bit2", tx[0], 0);
    rst = 1'b1;
    #1;
    chk("u0 midframe_reset tx", tx[0], 1);
    chk("u0 midframe_reset busy", busy[0], 0);
    chk("u0 midframe_reset ready", rdy[0], 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(0, 8'hA3, 1'b0, 8'h00, 1'b0);

    // Tick every clock.
    period = 1;
    phase = 0;
    run_frame(0, 8'h80, 1'b0, 8'h00, 1'b0);

    // VALID pulsed while busy, data changed after accept.
    period = 4;
    run_frame(0, 8'h3C, 1'b0, 8'h00, 1'b1);

    // Random words, instances and tick periods.
    for (int r = 0; r < 8; r++) begin
      idx = int'($urandom_range(0, 2));
      period = int'($urandom_range(1, 6));
      phase = 0;
      w = 8'($urandom);
      run_frame(idx, w, 1'b0, 8'h00, 1'b0);
      repeat (int'($urandom_range(0, 3))) clk_step(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_tick.md
Name: uart_tx_tick

Overview:
- Serial UART transmitter that consumes the single-cycle bit-rate tick produced by the frequency-divider pulse stage.
- Accepts one parallel word per valid/ready handshake. Frames it as start, data LSB-first, optional parity and stop bits. Drives the TX line for exactly one tick period per bit.
- Sits between the pulse stage (tick source) and the board TX pin. It does no clock division of its own.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- CLK_IN  input  1  system clock; all logic on the rising edge.
- RST_IN  input  1  asynchronous, active-high reset.
- TICK_IN  input  1  one-cycle bit-rate strobe from the pulse stage; one bit period = interval between ticks.
- DATA_IN  input  DATA_BITS  word to transmit; sampled only at accept.
- VALID_IN  input  1  DATA_IN holds a word to send.
- READY_OUT  output  1  block can accept a word this cycle.
- TX_OUT  output  1  serial line; idle high.
- BUSY_OUT  output  1  a frame is pending or in progress.

Behaviour:
- Reset (async, RST_IN = 1): state IDLE, TX_OUT = 1, BUSY_OUT = 0, READY_OUT = 1, shift register = 0, bit counter = 0. Takes effect immediately, including mid-frame; the line returns high with no partial stop bit. The first frame after release starts cleanly.
- READY_OUT = (state == IDLE), decoded from state.
- Accept: VALID_IN & READY_OUT on a rising edge.
  - Latches DATA_IN into the shift register and computes the parity bit.
  - Moves to SYNC and sets BUSY_OUT = 1 on the same edge.
  - Later DATA_IN changes have no effect.
- States and transitions (all timed by TICK_IN except IDLE -> SYNC):
  - IDLE: TX_OUT = 1. Goes to SYNC on accept; TICK_IN is ignored.
  - SYNC: TX_OUT = 1. On TICK_IN, goes to START and sets TX_OUT <= 0.
  - START: on TICK_IN, goes to DATA, sets TX_OUT <= data bit 0 and clears the bit counter.
  - DATA: on TICK_IN:
    - If counter < DATA_BITS-1: shifts, drives the next bit and increments the counter.
    - Otherwise: goes to PARITY when PARITY_EN = 1 (TX_OUT <= parity bit), else to STOP (TX_OUT <= 1).
  - PARITY: on TICK_IN, goes to STOP, sets TX_OUT <= 1 and clears the counter.
  - STOP: on TICK_IN:
    - If counter < STOP_BITS-1: increments the counter.
    - Otherwise: goes to IDLE and sets BUSY_OUT <= 0.
- Parity bit = XOR of the DATA_BITS latched bits, inverted when PARITY_ODD = 1.
- TX_OUT is registered and changes on the clock edge where TICK_IN = 1. Every bit, start included, lasts exactly one tick interval.
- Waiting in SYNC for the first tick takes 0 to 1 tick periods of extra idle-high. Between back-to-back frames the idle-high gap is therefore at least one clock and at most one tick period.
- TICK_IN high on every cycle is legal: one bit per clock.
- TICK_IN coinciding with accept in IDLE is ignored; the start bit begins on the next tick.
- VALID_IN while not ready is ignored; the word is not dropped from the source, which must hold it.
- Frame length in ticks = 1 + DATA_BITS + PARITY_EN + STOP_BITS, counted from the SYNC->START tick to the STOP->IDLE tick.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams IDLE, SYNC, START, DATA, PARITY, STOP (3-bit);
  - the frame-length function;
  - parameter legality checks.
- No sub-module inside this block. The top level instantiates it next to the pulse stage, with PULSE_OUT driving TICK_IN. A future uart_rx shares uart_pkg.

Test Plan:
- Defaults with TICK_IN every 4 clocks; send 0x55 -> TX_OUT = 0,1,0,1,0,1,0,1,0,1. Each level holds 4 clocks; BUSY_OUT is high from accept through the final tick, then READY_OUT = 1.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. With PARITY_ODD=1, same data -> parity bit 0. Frame is 11 ticks.
- STOP_BITS=2, send 0xFF with VALID_IN held high for two words -> two stop-bit periods high, then 1 to 4 idle clocks before the second start bit. The second word is accepted exactly once.
- Assert RST_IN mid-DATA for 1 cycle -> TX_OUT = 1 and BUSY_OUT = 0 immediately, READY_OUT = 1. The next word 0xA3 is transmitted correctly from its start bit.
- TICK_IN held high continuously, send 0x80 -> frame completes in 10 clocks after SYNC: TX_OUT = 0,0,0,0,0,0,0,0,1,1.
- VALID_IN pulsed during BUSY with DATA_IN = 0x3C; DATA_IN changed after accept -> no second accept. The transmitted word equals the value latched at accept.
